// File: rtl/decode_stage.sv
// RV32I decode stage: register file with writeback bypass, operand and
// control decode for OP/OP-IMM/LUI/AUIPC, and a one-entry output register
// with a valid/ready handshake on both sides.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Register file; must be clearable by reset, so it is kept in flops.
  logic [31:0] rf_reg [32];
  logic [31:0] wr_sel;

  // One write strobe per register; x0 never gets a strobe.
  for (genvar gi = 0; gi < 32; gi++) begin : g_wr_sel
    if (gi == 0) begin : g_zero
      assign wr_sel[gi] = 1'b0;
    end else begin : g_reg
      assign wr_sel[gi] = wb_en && (wb_rd == 5'(gi));
    end
  end

  // Register-file update: reset clears everything and overrides writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_sel[i]) rf_reg[i] <= wb_data;
      end
    end
  end

  // Source reads with same-cycle writeback bypass; x0 is hardwired to zero.
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (wb_en && (wb_rd == rs1)) ? wb_data : rf_reg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (wb_en && (wb_rd == rs2)) ? wb_data : rf_reg[rs2];

  // Handshake: a full output register can only refill when it is drained.
  logic valid_reg;
  logic accept;

  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  logic [31:0] a_next;
  logic [31:0] b_next;
  logic [2:0]  f3_next;
  logic [6:0]  f7_next;
  logic        we_next;
  logic        ill_next;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'd0};

  // Opcode decode into the operand/control values captured on accept.
  always_comb begin
    a_next   = '0;
    b_next   = '0;
    f3_next  = '0;
    f7_next  = '0;
    we_next  = 1'b0;
    ill_next = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        a_next  = rs1_val;
        b_next  = rs2_val;
        f3_next = instr[14:12];
        f7_next = instr[31:25];
        we_next = 1'b1;
      end
      OPC_OP_IMM: begin
        a_next  = rs1_val;
        b_next  = imm_i;  // low five bits double as the shift amount
        f3_next = instr[14:12];
        f7_next = ((instr[14:12] == 3'b101) && instr[30]) ? 7'h20 : 7'h00;
        we_next = 1'b1;
      end
      OPC_LUI: begin
        b_next  = imm_u;
        we_next = 1'b1;
      end
      OPC_AUIPC: begin
        a_next  = pc;
        b_next  = imm_u;
        we_next = 1'b1;
      end
      default: ill_next = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) we_next = 1'b0;
  end

  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [2:0]  f3_reg;
  logic [6:0]  f7_reg;
  logic [4:0]  rd_reg;
  logic        we_reg;
  logic        ill_reg;

  // Output register: load on accept, hold otherwise; valid drops once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      f3_reg    <= '0;
      f7_reg    <= '0;
      rd_reg    <= '0;
      we_reg    <= 1'b0;
      ill_reg   <= 1'b0;
    end else begin
      if (accept) begin
        valid_reg <= 1'b1;
        a_reg     <= a_next;
        b_reg     <= b_next;
        f3_reg    <= f3_next;
        f7_reg    <= f7_next;
        rd_reg    <= instr[11:7];
        we_reg    <= we_next;
        ill_reg   <= ill_next;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign A         = a_reg;
  assign B         = b_reg;
  assign funct3    = f3_reg;
  assign funct7    = f7_reg;
  assign rd        = rd_reg;
  assign rd_we     = we_reg;
  assign illegal   = ill_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver computes expected decodes from a
// reference register file and pushes them to a queue; a monitor compares the
// DUT outputs against the queue head every cycle the DUT shows out_valid.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  exp_t        sb[$];
  logic [31:0] ref_rf [32];

  task automatic chk(input string name, input logic [80:0] got, input logic [80:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] r, input logic we,
                              input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.f3 = f3; e.f7 = f7; e.rd = r; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Architectural register read as seen in the accept cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] rs, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (rs == 5'd0) return 32'd0;
    if (we && wr == rs) return wd;
    return ref_rf[rs];
  endfunction

  // Expected ALU-side view of one instruction, from the RV32I field rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] v1, input logic [31:0] v2);
    exp_t        e;
    logic [31:0] imm12;
    e = '0;
    e.rd  = ins[11:7];
    imm12 = {20'd0, ins[31:20]};
    if (ins[31]) imm12 = imm12 - 32'd4096;
    case (ins[6:0])
      7'b0110011: begin
        e.a = v1; e.b = v2; e.f3 = ins[14:12]; e.f7 = ins[31:25]; e.we = 1'b1;
      end
      7'b0010011: begin
        e.a = v1; e.b = imm12; e.f3 = ins[14:12]; e.we = 1'b1;
        if (ins[14:12] == 3'd5 && ins[30]) e.f7 = 7'h20;
      end
      7'b0110111: begin
        e.b = ins & 32'hFFFF_F000; e.we = 1'b1;
      end
      7'b0010111: begin
        e.a = p; e.b = ins & 32'hFFFF_F000; e.we = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] base;
    logic [6:0]  op;
    base = $urandom;
    case ($urandom_range(0, 5))
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0110111;
      3: op = 7'b0010111;
      4: op = 7'b0000011;
      default: op = 7'($urandom);
    endcase
    return {base[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            base[14:12], 5'($urandom_range(0, 7)), op};
  endfunction

  // One clock of stimulus: drive at negedge, predict handshake, update model.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic ordy, input logic r, input logic use_dir, input exp_t dir);
    logic exp_ir;
    logic acc;
    exp_t e;
    @(negedge clk);
    in_valid = iv; instr = ins; pc = p; wb_en = we; wb_rd = wr; wb_data = wd;
    out_ready = ordy; rst = r;
    #1;
    exp_ir = (sb.size() == 0) || ordy;
    if (!r) chk("in_ready", 81'(in_ready), 81'(exp_ir));
    acc = iv && exp_ir && !r;
    e = model(ins, p, ref_read(ins[19:15], we, wr, wd), ref_read(ins[24:20], we, wr, wd));
    if (r) begin
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    end else if (we && wr != 5'd0) begin
      ref_rf[wr] = wd;
    end
    #2;
    if (r) sb.delete();
    else if (acc) sb.push_back(use_dir ? dir : e);
  endtask

  task automatic wb_only(input logic [4:0] wr, input logic [31:0] wd);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, wr, wd, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic issue(input logic [31:0] ins, input logic ordy, input logic use_dir, input exp_t dir);
    cyc(1'b1, ins, 32'h0000_1000, 1'b0, 5'd0, 32'd0, ordy, 1'b0, use_dir, dir);
  endtask

  task automatic chk_zero(input string name);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 81'(out_valid), 81'(0));
    chk({name, "_outs"}, {A, B, funct3, funct7, rd, rd_we, illegal}, 81'(0));
  endtask

  // Monitor: compare the held output against the queue head; pop on consume.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("out_valid", 81'(out_valid), 81'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        chk("decode", {A, B, funct3, funct7, rd, rd_we, illegal}, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  logic        r_iv;
  logic [31:0] r_ins;
  logic [31:0] r_pc;
  logic        r_we;
  logic [4:0]  r_wr;
  logic [31:0] r_wd;
  logic        r_ordy;
  logic        r_rst;

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, '0);
    chk_zero("reset");

    // add x3,x5,x5 after x5 <- 7
    wb_only(5'd5, 32'd7);
    issue(32'h005281B3, 1'b1, 1'b1, mk(32'd7, 32'd7, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0));
    // srai / addi with x2 = 0x80000000
    wb_only(5'd2, 32'h8000_0000);
    issue(32'h40315093, 1'b1, 1'b1, mk(32'h8000_0000, 32'h0000_0403, 3'd5, 7'h20, 5'd1, 1'b1, 1'b0));
    issue(32'hFFF10093, 1'b1, 1'b1, mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd0, 7'h00, 5'd1, 1'b1, 1'b0));
    // sub x7,x6,x0 with a same-cycle writeback to x6
    cyc(1'b1, 32'h400303B3, 32'd0, 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1,
        mk(32'hDEAD_BEEF, 32'd0, 3'd0, 7'h20, 5'd7, 1'b1, 1'b0));
    // three-cycle stall with a waiting instruction
    issue(32'h00628233, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) issue(32'h00A30313, 1'b0, 1'b0, '0);
    issue(32'h00A30313, 1'b1, 1'b0, '0);
    // illegal opcode, write to x0 dropped, x0 always reads zero
    issue(32'h00002083, 1'b1, 1'b1, mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd1, 1'b0, 1'b1));
    issue(32'h00500013, 1'b1, 1'b1, mk(32'd0, 32'd5, 3'd0, 7'h00, 5'd0, 1'b0, 1'b0));
    wb_only(5'd0, 32'h1234_5678);
    issue(32'h00000233, 1'b1, 1'b1, mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd4, 1'b1, 1'b0));
    // LUI / AUIPC
    issue(32'hABCDE2B7, 1'b1, 1'b1, mk(32'd0, 32'hABCD_E000, 3'd0, 7'h00, 5'd5, 1'b1, 1'b0));
    issue(32'h12345297, 1'b1, 1'b1, mk(32'h0000_1000, 32'h1234_5000, 3'd0, 7'h00, 5'd5, 1'b1, 1'b0));
    // reset in the middle of a stall discards the held output and clears x5
    wb_only(5'd5, 32'h55);
    issue(32'h005281B3, 1'b0, 1'b1, mk(32'h55, 32'h55, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0));
    issue(32'h00A30313, 1'b0, 1'b0, '0);
    cyc(1'b1, 32'h00A30313, 32'd0, 1'b1, 5'd5, 32'h99, 1'b0, 1'b1, 1'b0, '0);
    chk_zero("mid_reset");
    issue(32'h005281B3, 1'b1, 1'b1, mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0));

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      r_iv   = ($urandom_range(0, 3) != 0);
      r_ins  = rand_instr();
      r_pc   = $urandom;
      r_we   = 1'($urandom_range(0, 1));
      r_wr   = 5'($urandom_range(0, 7));
      r_wd   = $urandom;
      r_ordy = ($urandom_range(0, 3) != 0);
      r_rst  = ($urandom_range(0, 99) == 0);
      cyc(r_iv, r_ins, r_pc, r_we, r_wr, r_wd, r_ordy, r_rst, 1'b0, '0);
    end

    for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
    chk("drain", 81'(sb.size()), 81'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, register count fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instr/pc presented by fetch are valid.
REQ-005 in_ready  output  1  stage accepts instr/pc this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 wb_en  input  1  register-file write enable from writeback.
REQ-009 wb_rd  input  5  register-file write index.
REQ-010 wb_data  input  32  register-file write data.
REQ-011 out_valid  output  1  decoded operation valid toward ALU.
REQ-012 out_ready  input  1  ALU side consumes the operation this cycle.
REQ-013 A  output  32  ALU first operand.
REQ-014 B  output  32  ALU second operand.
REQ-015 funct3  output  3  ALU operation select.
REQ-016 funct7  output  7  ALU operation modifier (0x20 = SUB/SRA, else 0x00).
REQ-017 rd  output  5  destination register index.
REQ-018 rd_we  output  1  result is to be written to rd.
REQ-019 illegal  output  1  instr is not a supported opcode.

Function
REQ-020 Register file: 32 x 32 bits; x0 reads 0; wb_en with wb_rd=0 ignored; write on clk edge when wb_en=1 and rst=0.
REQ-021 Read bypass: rs1/rs2 (instr[19:15]/[24:20]) equal to nonzero wb_rd with wb_en=1 in the accept cycle read wb_data.
REQ-022 Handshake: accept when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-023 Latency: accepted instr appears on outputs with out_valid=1 the next cycle; one instr per cycle at full throughput.
REQ-024 Hold: while out_valid && !out_ready, all outputs stable; no accept.
REQ-025 out_valid: set on accept; cleared when out_ready=1 and no accept in the same cycle.
REQ-026 Operands captured at accept; later writebacks do not alter a held output.
REQ-027 OP (opcode 0110011): A=rs1, B=rs2, funct3=instr[14:12], funct7=instr[31:25], rd_we=1.
REQ-028 OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20], funct3=instr[14:12], funct7=0x20 only if funct3=101 and instr[30]=1, else 0x00; rd_we=1.
REQ-029 OP-IMM shifts: B[4:0]=instr[24:20]; upper bits of B irrelevant to ALU.
REQ-030 LUI (0110111): A=0, B={instr[31:12],12'b0}, funct3=000, funct7=0x00, rd_we=1.
REQ-031 AUIPC (0010111): A=pc, B={instr[31:12],12'b0}, funct3=000, funct7=0x00, rd_we=1.
REQ-032 Any other opcode: illegal=1, rd_we=0, A=B=0, funct3=000, funct7=0x00; still handshaken normally.
REQ-033 rd=instr[11:7] for all opcodes; rd_we forced 0 when rd=0.

Reset
REQ-034 rst=1 on a clk edge: out_valid=0, A=B=0, funct3=0, funct7=0, rd=0, rd_we=0, illegal=0, all 32 registers cleared to 0.
REQ-035 rst=1 overrides accept and wb_en in the same cycle; a held output mid-stall is discarded.
REQ-036 in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-037 wb x5=0x00000007, then accept `add x3,x5,x5` (0x005281B3), out_ready=1 -> next cycle A=7, B=7, funct3=0, funct7=0x00, rd=3, rd_we=1.
REQ-038 Accept `srai x1,x2,3` (0x40315093) with x2=0x80000000 -> funct3=101, funct7=0x20, B[4:0]=3, A=0x80000000; `addi x1,x2,-1` (0xFFF10093) -> B=0xFFFFFFFF, funct7=0x00.
REQ-039 Same cycle wb_en=1, wb_rd=6, wb_data=0xDEADBEEF and accept `sub x7,x6,x0` (0x400303B3) -> A=0xDEADBEEF, B=0, funct7=0x20.
REQ-040 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instr appears following cycle, none dropped or duplicated.
REQ-041 Accept opcode 0000011 -> illegal=1, rd_we=0; `addi x0,x0,5` -> rd_we=0; wb to x0 then read x0 -> 0.
REQ-042 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all outputs 0, x5 reads 0.
